// File: rtl/adc_trigger_capture_if.sv
// ============================================================================
// Module   : adc_trigger_capture_if
// Brief    : Sample stream and read-out handshake bundle for adc_trigger_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_trigger_capture_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_sample_valid;
    logic [DATA_WIDTH-1:0] i_sample;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_rd_last;

    modport master (
        output i_sample_valid,
        output i_sample,
        output i_rd_en,
        input  o_rd_data,
        input  o_rd_valid,
        input  o_rd_last
    );

    modport slave (
        input  i_sample_valid,
        input  i_sample,
        input  i_rd_en,
        output o_rd_data,
        output o_rd_valid,
        output o_rd_last
    );
endinterface

`default_nettype wire

// File: rtl/adc_trigger_capture.sv
// ============================================================================
// Module   : adc_trigger_capture
// Brief    : Armed circular capture of ADC samples around a level-crossing
//            trigger, frozen record drained via a read handshake.
//            Optional macro CAPTURE_DECIMATE_EN adds i_decim sample decimation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_trigger_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    adc_trigger_capture_if.slave       bus,
`ifdef CAPTURE_DECIMATE_EN
    input  wire logic [3:0]            i_decim,
`endif
    input  wire logic                  i_arm,
    input  wire logic [DATA_WIDTH-1:0] i_trig_level,
    input  wire logic                  i_trig_rising,
    input  wire logic [DEPTH_LOG2-1:0] i_pretrig,
    output logic                       o_armed,
    output logic                       o_triggered,
    output logic                       o_done
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_PRETRIG   = 3'd1;
    localparam logic [2:0] c_WAIT_TRIG = 3'd2;
    localparam logic [2:0] c_POST      = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;
    localparam logic [2:0] c_READ      = 3'd5;

    logic [2:0]            r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_idx;
    logic [DEPTH_LOG2-1:0] r_count;
    logic [DEPTH_LOG2-1:0] r_pretrig;
    logic [DATA_WIDTH-1:0] r_level;
    logic                  r_rising;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  r_triggered;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_last;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_capturing;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_cross;
    logic                  w_trig;
    logic                  w_rd_fire;
    logic                  w_rd_final;
    logic [DEPTH_LOG2-1:0] w_post_cnt;

    assign w_capturing = (r_state == c_PRETRIG) || (r_state == c_WAIT_TRIG) ||
                         (r_state == c_POST);

`ifdef CAPTURE_DECIMATE_EN
    logic [3:0] r_decim;
    logic [3:0] r_decim_cnt;

    // Only every (decim+1)-th valid sample is taken; the counter restarts at arm.
    assign w_tick = (r_decim_cnt == r_decim);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_decim     <= 4'd0;
            r_decim_cnt <= 4'd0;
        end else if ((r_state == c_IDLE) && i_arm) begin
            r_decim     <= i_decim;
            r_decim_cnt <= 4'd0;
        end else if (w_capturing && bus.i_sample_valid) begin
            r_decim_cnt <= w_tick ? 4'd0 : r_decim_cnt + 4'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_accept   = w_capturing && bus.i_sample_valid && w_tick;
    assign w_cross    = r_rising ? ((r_prev <  r_level) && (bus.i_sample >= r_level))
                                 : ((r_prev >= r_level) && (bus.i_sample <  r_level));
    assign w_trig     = w_accept && r_prev_valid && w_cross;
    // DEPTH - pretrig - 1 is the bitwise complement in DEPTH_LOG2 bits.
    assign w_post_cnt = ~r_pretrig;
    assign w_rd_fire  = bus.i_rd_en && ((r_state == c_DONE) || (r_state == c_READ));
    assign w_rd_final = &r_rd_idx;

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.i_sample;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_idx     <= '0;
            r_count      <= '0;
            r_pretrig    <= '0;
            r_level      <= '0;
            r_rising     <= 1'b0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_triggered  <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && w_rd_final;

            if (w_accept) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev       <= bus.i_sample;
                r_prev_valid <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (i_arm) begin
                        r_level      <= i_trig_level;
                        r_rising     <= i_trig_rising;
                        r_pretrig    <= i_pretrig;
                        r_count      <= '0;
                        r_prev_valid <= 1'b0;
                        r_state      <= (i_pretrig == '0) ? c_WAIT_TRIG : c_PRETRIG;
                    end
                end
                c_PRETRIG: begin
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == r_pretrig - 1'b1) begin
                            r_state <= c_WAIT_TRIG;
                        end
                    end
                end
                c_WAIT_TRIG: begin
                    if (w_trig) begin
                        r_triggered <= 1'b1;
                        r_rd_ptr    <= r_wr_ptr - r_pretrig;
                        r_rd_idx    <= '0;
                        r_count     <= w_post_cnt;
                        r_state     <= (w_post_cnt == '0) ? c_DONE : c_POST;
                    end
                end
                c_POST: begin
                    if (w_accept) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == {{(DEPTH_LOG2-1){1'b0}}, 1'b1}) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE, c_READ: begin
                    if (w_rd_fire) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_rd_idx  <= r_rd_idx + 1'b1;
                        if (w_rd_final) begin
                            r_triggered <= 1'b0;
                            r_state     <= c_IDLE;
                        end else begin
                            r_state <= c_READ;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign o_armed        = (r_state == c_PRETRIG) || (r_state == c_WAIT_TRIG);
    assign o_done         = (r_state == c_DONE) || (r_state == c_READ);
    assign o_triggered    = r_triggered;
    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_rd_last  = r_rd_last;

endmodule

`default_nettype wire
